// File: rtl/fd_pkg.sv
// rtl/fd_pkg.sv - shared constants and entry type for the fetch/decode buffer
package fd_pkg;

  localparam int unsigned FD_PC_W    = 32;
  localparam int unsigned FD_INSTR_W = 32;

  // Decode sees this pc/instruction pair as a bubble when the buffer is empty
  localparam logic [FD_PC_W-1:0]    PC_RESET = 32'h0000_3000;
  localparam logic [FD_INSTR_W-1:0] NOP      = 32'h0000_0000;

  typedef struct packed {
    logic [FD_PC_W-1:0]    pc;
    logic [FD_INSTR_W-1:0] instr;
  } fd_entry_t;

endpackage

// File: rtl/fd_buffer_mem.sv
// rtl/fd_buffer_mem.sv - DEPTH-entry register array, one write port, async read port
module fd_buffer_mem
  import fd_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  fd_entry_t       wdata,
  input  logic [AW-1:0]   raddr,
  output fd_entry_t       rdata
);

  // Contents are never reset; occupancy tracking decides what is meaningful
  fd_entry_t mem [DEPTH];

  // Write the addressed entry on the rising edge
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fd_buffer.sv
// rtl/fd_buffer.sv - fetch-to-decode instruction FIFO with flush; FD_BUFFER_BYPASS_EN adds zero-latency bypass
module fd_buffer
  import fd_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned INSTR_W = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  input  logic [PC_W-1:0]            in_pc,
  input  logic [INSTR_W-1:0]         in_instr,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [PC_W-1:0]            out_pc,
  output logic [INSTR_W-1:0]         out_instr,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          empty;
  logic          full;
  logic          byp;
  logic          push;
  logic          pop;
  logic          wr_en;
  fd_entry_t     wdata;
  fd_entry_t     rdata;

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));

`ifdef FD_BUFFER_BYPASS_EN
  // An empty buffer forwards the fetch slot straight to decode
  assign byp = empty && in_valid && !flush;
`else
  assign byp = 1'b0;
`endif

  // Accept depends on occupancy only, so decode stalls never reach fetch combinationally
  assign in_ready = !full || flush;
  assign push     = in_valid && !full && !flush;
  assign pop      = !empty && out_ready && !flush;
  // A bypassed instruction that decode takes immediately never touches storage
  assign wr_en    = push && !(byp && out_ready);

  assign wdata.pc    = FD_PC_W'(in_pc);
  assign wdata.instr = FD_INSTR_W'(in_instr);

  fd_buffer_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Head entry toward decode, bubble values when nothing is held
  always_comb begin
    out_valid = !empty || byp;
    out_pc    = PC_W'(PC_RESET);
    out_instr = INSTR_W'(NOP);
    if (!empty) begin
      out_pc    = PC_W'(rdata.pc);
      out_instr = INSTR_W'(rdata.instr);
    end else if (byp) begin
      out_pc    = in_pc;
      out_instr = in_instr;
    end
  end

  // Pointers and occupancy; flush wins over any same-cycle push or pop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_en && !pop) begin
        cnt <= cnt + 1'b1;
      end else if (!wr_en && pop) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign count = cnt;

endmodule

// File: tb/tb_fd_buffer.sv
// tb/tb_fd_buffer.sv - scoreboard bench for fd_buffer (optionally with FD_BUFFER_BYPASS_EN)
module tb_fd_buffer;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
  logic        flush;
  logic [1:0]  count;

  int checks;
  int fails;

  logic [31:0] sb_pc[$];

  fd_buffer #(
    .DEPTH   (2),
    .PC_W    (32),
    .INSTR_W (32)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_ready (out_ready),
    .flush     (flush),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a fetch slot; expect_accept records it in the scoreboard
  task automatic drive(input logic [31:0] pc, input bit expect_accept);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = instr_of(pc);
    if (expect_accept) sb_pc.push_back(pc);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_pc    = 32'h0;
    in_instr = 32'h0;
  endtask

  // Monitor: every decode handshake must match the oldest expected entry
  always @(negedge clk) begin
    if (reset_n && !flush && out_valid && out_ready) begin
      logic [31:0] exp_pc;
      checks++;
      if (sb_pc.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out: got pc %h expected no output", out_pc);
      end else begin
        exp_pc = sb_pc.pop_front();
        if (out_pc !== exp_pc || out_instr !== instr_of(exp_pc)) begin
          fails++;
          $display("FAIL out_entry: got %h/%h expected %h/%h", out_pc, out_instr, exp_pc, instr_of(exp_pc));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    fails     = 0;
    reset_n   = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    idle();
    repeat (3) step();
    reset_n = 1'b1;
    #1;
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_pc", out_pc, 32'h0000_3000);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("rst_count", {30'h0, count}, 32'h0);

    // Fill with decode stalled, then drain
    step();
    drive(32'h3000, 1'b1);
    step();
    drive(32'h3004, 1'b1);
    step();
    check("fill_count", {30'h0, count}, 32'h2);
    check("fill_in_ready", {31'h0, in_ready}, 32'h0);
    drive(32'h3008, 1'b0);
    step();
    check("refused_count", {30'h0, count}, 32'h2);
    idle();
    out_ready = 1'b1;
    step();
    check("drain_count1", {30'h0, count}, 32'h1);
    step();
    check("drain_count0", {30'h0, count}, 32'h0);
    check("drain_out_valid", {31'h0, out_valid}, 32'h0);

    // Streaming through both pointers wrapping
    for (int i = 0; i < 8; i++) begin
      drive(32'h3000 + 32'(4 * i), 1'b1);
      step();
`ifdef FD_BUFFER_BYPASS_EN
      check("stream_count", {30'h0, count}, 32'h0);
`else
      check("stream_count", {30'h0, count}, 32'h1);
      check("stream_out_valid", {31'h0, out_valid}, 32'h1);
`endif
    end
    idle();
    step();
    check("stream_end_count", {30'h0, count}, 32'h0);

    // Flush has priority over push and pop
    out_ready = 1'b0;
    drive(32'h3020, 1'b1);
    step();
    drive(32'h3024, 1'b1);
    step();
    check("preflush_count", {30'h0, count}, 32'h2);
    drive(32'h3100, 1'b0);
    out_ready = 1'b1;
    flush     = 1'b1;
    sb_pc.delete();
    #1;
    check("flush_in_ready", {31'h0, in_ready}, 32'h1);
    step();
    flush = 1'b0;
    idle();
    #1;
    check("flush_count", {30'h0, count}, 32'h0);
    check("flush_out_valid", {31'h0, out_valid}, 32'h0);
    check("flush_out_pc", out_pc, 32'h0000_3000);

    // Full with a pop: push refused this cycle, accepted next
    out_ready = 1'b0;
    drive(32'h3030, 1'b1);
    step();
    drive(32'h3034, 1'b1);
    step();
    check("fullpop_pre_count", {30'h0, count}, 32'h2);
    out_ready = 1'b1;
    drive(32'h3038, 1'b0);
    step();
    check("fullpop_count", {30'h0, count}, 32'h1);
    check("fullpop_in_ready", {31'h0, in_ready}, 32'h1);
    sb_pc.push_back(32'h3038);
    step();
    check("fullpop_next_count", {30'h0, count}, 32'h1);
    idle();
    step();
    check("fullpop_end_count", {30'h0, count}, 32'h0);

`ifdef FD_BUFFER_BYPASS_EN
    // Empty buffer forwards the fetch slot in the same cycle
    drive(32'h3040, 1'b1);
    #1;
    check("byp_out_valid", {31'h0, out_valid}, 32'h1);
    check("byp_out_pc", out_pc, 32'h3040);
    step();
    idle();
    check("byp_count", {30'h0, count}, 32'h0);
`endif

    // Asynchronous reset while holding two entries
    out_ready = 1'b0;
    drive(32'h3050, 1'b0);
    step();
    drive(32'h3054, 1'b0);
    step();
    idle();
    check("prereset_count", {30'h0, count}, 32'h2);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_count", {30'h0, count}, 32'h0);
    check("async_rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("async_rst_out_pc", out_pc, 32'h0000_3000);
    step();
    reset_n = 1'b1;
    step();

    check("sb_empty", 32'(sb_pc.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
